alu_result_collector: RTL and testbench
=======================================

Name: alu_result_collector

Overview:
- Downstream stage of the ALU control unit.
- Samples the output bus during the control unit's PUSHA/PUSHQ states.
- Assembles a {res_hi, res_lo} result according to the op_code that was latched at BEGIN.
- Buffers completed results in a 2-entry FIFO that a consumer drains through a valid/ready handshake.
- Detects protocol violations (push strobes out of order) and overruns (result arrives while the FIFO is full).

Parameters:
- W, 8, datapath width of the output bus, A, Q and each result half.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- begin_in  input  1  BEGIN pulse seen by the control unit; latches op_code.
- op_code  input  2  operation code: 00 add, 01 sub, 10 mul, 11 div.
- push_a  input  1  high while the control unit is in PUSHA; outbus carries A.
- push_q  input  1  high while the control unit is in PUSHQ; outbus carries Q.
- outbus  input  W  ALU output bus.
- res_ready  input  1  consumer accepts the head entry.
- clr_err  input  1  clears the sticky error flags.
- res_valid  output  1  the FIFO head holds a result.
- res_hi  output  W  high word of the head result.
- res_lo  output  W  low word of the head result.
- res_op  output  2  op_code of the head result.
- busy  output  1  a capture is in progress (state not IDLE).
- err_proto  output  1  sticky protocol-error flag.
- err_ovr  output  1  sticky overrun flag.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, FIFO empty.
  - res_valid=0, res_hi=0, res_lo=0, res_op=0, busy=0, err_proto=0, err_ovr=0.
  - A reset during a capture discards the partial result.
- Capture FSM states: IDLE, WAIT1, WAIT2. All inputs are sampled on the rising edge.
- IDLE:
  - begin_in=1: latch op_code into op_r and go to WAIT1.
  - push_a or push_q=1: set err_proto and stay in IDLE.
- WAIT1 expects the first push:
  - add/sub/mul expect push_a; div expects push_q.
  - Correct strobe, add/sub: complete with res_lo=outbus, res_hi=sign-extension of outbus[W-1]. Go to IDLE.
  - Correct strobe, mul: store outbus as hi_r. Go to WAIT2.
  - Correct strobe, div: store outbus (the quotient) as lo_r. Go to WAIT2.
- WAIT2 expects the second push: mul expects push_q, div expects push_a.
  - mul: complete with res_hi=hi_r, res_lo=outbus.
  - div: complete with res_hi=outbus (remainder), res_lo=lo_r (quotient).
  - Go to IDLE.
- Protocol errors in WAIT1/WAIT2:
  - Wrong strobe, or push_a and push_q high together: set err_proto, discard the transaction, go to IDLE.
  - begin_in=1: set err_proto, discard, latch the new op_code, go to WAIT1. begin_in has priority over push strobes in the same cycle.
- Completion writes {op_r, hi, lo} into the FIFO on the same edge that samples the final push.
  - res_valid rises on the next cycle, so latency is 1 clock from the final push cycle.
- FIFO: 2 entries, with a write pointer, a read pointer and a 2-bit count.
  - res_hi, res_lo and res_op always show the head entry. They show 0 when the FIFO is empty.
  - A pop occurs when res_valid & res_ready.
  - Completion when count=2 with no pop that cycle: drop the new result, set err_ovr, leave the FIFO unchanged.
  - Completion when count=2 with a pop the same cycle: accept the result, no overrun, count stays 2.
  - Simultaneous push and pop at count=1: count stays 1 and the head advances to the new entry.
  - Pointers wrap modulo 2.
- res_ready while res_valid=0 is ignored.
- clr_err=1 clears both sticky flags on the next edge. An error event in the same cycle wins, so the flag stays 1.
- busy=1 in WAIT1 and WAIT2.

Test Plan:
- add, W=8: begin op=00, then push_a with outbus=0xF3.
  - res_valid=1 the next cycle; res_hi=0xFF, res_lo=0xF3, res_op=00.
- mul: begin op=10, push_a outbus=0x12, then push_q outbus=0x34, res_ready=1.
  - res_hi=0x12, res_lo=0x34 for one cycle, then res_valid=0.
- div: begin op=11, push_q outbus=0x05, then push_a outbus=0x02.
  - res_lo=0x05, res_hi=0x02, res_op=11.
- Overrun: three add results with res_ready=0.
  - The first two are retained in order, err_ovr=1 after the third.
  - Then res_ready=1 for two cycles pops both; clr_err clears err_ovr.
- Protocol error:
  - push_q in IDLE → err_proto=1.
  - mul with push_q first → err_proto=1, FIFO stays empty, busy=0.
- Asynchronous reset mid-mul after push_a (not clock-aligned): all outputs 0 immediately. A subsequent add completes normally.

Source files
------------

// File: rtl/alu_result_collector_if.sv
// Bundle between the ALU control unit / result consumer and the result collector.
// Handshake: a result is transferred on every rising edge where res_valid and
// res_ready are both high; res_valid is never withdrawn until that transfer,
// and res_ready while res_valid is low has no effect.
interface alu_result_collector_if #(
  parameter int W = 8
);
  logic         begin_in;
  logic [1:0]   op_code;
  logic         push_a;
  logic         push_q;
  logic [W-1:0] outbus;
  logic         res_ready;
  logic         clr_err;
  logic         res_valid;
  logic [W-1:0] res_hi;
  logic [W-1:0] res_lo;
  logic [1:0]   res_op;
  logic         busy;
  logic         err_proto;
  logic         err_ovr;

  // Driver side: the control unit plus the result consumer.
  modport master (
    output begin_in, op_code, push_a, push_q, outbus, res_ready, clr_err,
    input  res_valid, res_hi, res_lo, res_op, busy, err_proto, err_ovr
  );

  // Collector side.
  modport slave (
    input  begin_in, op_code, push_a, push_q, outbus, res_ready, clr_err,
    output res_valid, res_hi, res_lo, res_op, busy, err_proto, err_ovr
  );
endinterface

// File: rtl/alu_result_collector.sv
// ALU result collector: samples the control unit's output bus during the
// push strobes, assembles {hi, lo} by op code and queues results in a
// 2-entry FIFO drained through a valid/ready handshake.
module alu_result_collector #(
  parameter int W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  alu_result_collector_if.slave bus,
  output logic [1:0]           o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT1 = 2'd1,
    S_WAIT2 = 2'd2
  } state_t;

  localparam logic [1:0] OP_DIV = 2'b11;

  state_t       r_state;
  logic [1:0]   r_op;
  logic [W-1:0] r_hi;
  logic [W-1:0] r_lo;
  logic         r_busy;

  logic [W-1:0] r_mem_hi [2];
  logic [W-1:0] r_mem_lo [2];
  logic [1:0]   r_mem_op [2];
  logic         r_wptr;
  logic         r_rptr;
  logic [1:0]   r_count;
  logic         r_err_proto;
  logic         r_err_ovr;

  logic         w_any_push;
  logic         w_ok;
  logic         w_done;
  logic         w_perr;
  logic [W-1:0] w_res_hi;
  logic [W-1:0] w_res_lo;
  logic         w_valid;
  logic         w_pop;
  logic         w_push;
  logic         w_ovr;

  assign w_any_push = bus.push_a | bus.push_q;

  // Decode the current strobe against the expected one and form the result.
  always_comb begin
    w_ok     = 1'b0;
    w_done   = 1'b0;
    w_perr   = 1'b0;
    w_res_hi = '0;
    w_res_lo = '0;
    case (r_state)
      S_IDLE: begin
        w_perr = ~bus.begin_in & w_any_push;
      end
      S_WAIT1: begin
        // div delivers the quotient first (on push_q); all others start with A.
        w_ok   = (r_op == OP_DIV) ? (bus.push_q & ~bus.push_a)
                                  : (bus.push_a & ~bus.push_q);
        w_perr = bus.begin_in | (w_any_push & ~w_ok);
        if (!bus.begin_in && w_ok && !r_op[1]) begin
          w_done   = 1'b1;
          w_res_lo = bus.outbus;
          w_res_hi = {W{bus.outbus[W-1]}};
        end
      end
      S_WAIT2: begin
        w_ok   = (r_op == OP_DIV) ? (bus.push_a & ~bus.push_q)
                                  : (bus.push_q & ~bus.push_a);
        w_perr = bus.begin_in | (w_any_push & ~w_ok);
        if (!bus.begin_in && w_ok) begin
          w_done = 1'b1;
          if (r_op == OP_DIV) begin
            w_res_hi = bus.outbus;
            w_res_lo = r_lo;
          end else begin
            w_res_hi = r_hi;
            w_res_lo = bus.outbus;
          end
        end
      end
      default: ;
    endcase
  end

  // Capture FSM: op latch, first-half storage and registered busy.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_op    <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.begin_in) begin
            r_op    <= bus.op_code;
            r_state <= S_WAIT1;
            r_busy  <= 1'b1;
          end
        end
        S_WAIT1, S_WAIT2: begin
          if (bus.begin_in) begin
            // A new BEGIN aborts the current capture and starts over.
            r_op    <= bus.op_code;
            r_state <= S_WAIT1;
            r_busy  <= 1'b1;
          end else if (w_any_push && !w_ok) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else if (w_ok) begin
            if (r_state == S_WAIT1 && r_op[1]) begin
              if (r_op == OP_DIV) r_lo <= bus.outbus;
              else                r_hi <= bus.outbus;
              r_state <= S_WAIT2;
            end else begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign w_valid = (r_count != 2'd0);
  assign w_pop   = w_valid & bus.res_ready;
  // A full FIFO still accepts a result when the head leaves on the same edge.
  assign w_push  = w_done & ((r_count != 2'd2) | w_pop);
  assign w_ovr   = w_done & (r_count == 2'd2) & ~w_pop;

  // Result FIFO storage, pointers and occupancy.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wptr  <= 1'b0;
      r_rptr  <= 1'b0;
      r_count <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem_hi[r_wptr] <= w_res_hi;
        r_mem_lo[r_wptr] <= w_res_lo;
        r_mem_op[r_wptr] <= r_op;
        r_wptr           <= ~r_wptr;
      end
      if (w_pop) r_rptr <= ~r_rptr;
      r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

  // Sticky error flags: a new event outranks a same-cycle clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_err_proto <= 1'b0;
      r_err_ovr   <= 1'b0;
    end else begin
      r_err_proto <= w_perr | (r_err_proto & ~bus.clr_err);
      r_err_ovr   <= w_ovr  | (r_err_ovr   & ~bus.clr_err);
    end
  end

  assign bus.res_valid = w_valid;
  assign bus.res_hi    = w_valid ? r_mem_hi[r_rptr] : '0;
  assign bus.res_lo    = w_valid ? r_mem_lo[r_rptr] : '0;
  assign bus.res_op    = w_valid ? r_mem_op[r_rptr] : 2'b00;
  assign bus.busy      = r_busy;
  assign bus.err_proto = r_err_proto;
  assign bus.err_ovr   = r_err_ovr;
  assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_alu_result_collector.sv
// Bench for alu_result_collector: directed scenarios plus randomized traffic,
// checked by a transaction-level model and an expected-result queue.
module tb_alu_result_collector;
  localparam int W = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] dbg_state;

  // Clock and reset
  always #5 clk = ~clk;

  alu_result_collector_if #(.W(W)) bus();

  alu_result_collector #(.W(W)) dut (
    .clk         (clk),
    .reset       (rst_n),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // Model state
  logic [17:0] exp_q[$];
  int          model_count = 0;
  logic        exp_proto = 1'b0;
  logic        exp_ovr = 1'b0;
  logic        tb_done = 1'b0;
  logic        tb_perr = 1'b0;
  logic [17:0] tb_res = '0;
  logic        rand_rdy = 1'b0;
  int          n_checks = 0;
  int          n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s actual=0x%0h required=0x%0h at t=%0t", name, act, req, $time);
  endtask

  // Result as the consumer should see it: {op, hi, lo}.
  // a = value carried with push_a, q = value carried with push_q.
  function automatic logic [17:0] ref_result(input logic [1:0] op, input logic [7:0] a,
                                             input logic [7:0] q);
    int          sa;
    logic [17:0] r;
    sa = int'($signed(a));
    case (op)
      2'b00, 2'b01: r = {op, 16'(sa)};
      // mul: A is the high word, Q the low; div: A is the remainder (high), Q the quotient (low).
      default:      r = {op, a, q};
    endcase
    return r;
  endfunction

  // Reference model: FIFO occupancy, overrun and sticky flags per clock edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_count = 0;
      exp_q.delete();
      exp_proto = 1'b0;
      exp_ovr   = 1'b0;
    end else begin
      bit pop;
      bit ovr;
      pop = (model_count > 0) && bus.res_ready;
      ovr = tb_done && (model_count == 2) && !pop;
      if (tb_done && !ovr) begin
        exp_q.push_back(tb_res);
        model_count++;
      end
      if (pop) model_count--;
      exp_proto = tb_perr | (exp_proto & ~bus.clr_err);
      exp_ovr   = ovr     | (exp_ovr   & ~bus.clr_err);
    end
  end

  // Monitor / scoreboard: compare DUT outputs away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      bit exp_v;
      exp_v = (exp_q.size() != 0);
      check("res_valid", 32'(bus.res_valid), 32'(exp_v));
      if (exp_v) check("head", 32'({bus.res_op, bus.res_hi, bus.res_lo}), 32'(exp_q[0]));
      else       check("empty_zero", 32'({bus.res_op, bus.res_hi, bus.res_lo}), 32'd0);
      check("err_proto", 32'(bus.err_proto), 32'(exp_proto));
      check("err_ovr", 32'(bus.err_ovr), 32'(exp_ovr));
      if (exp_v && bus.res_ready) void'(exp_q.pop_front());
    end
  end

  // Driver: apply one cycle of inputs, advance to just after the edge.
  task automatic drive(input logic b, input logic [1:0] op, input logic pa, input logic pq,
                       input logic [7:0] ob, input logic done, input logic [17:0] res,
                       input logic perr);
    bus.begin_in = b;
    bus.op_code  = op;
    bus.push_a   = pa;
    bus.push_q   = pq;
    bus.outbus   = ob;
    tb_done      = done;
    tb_res       = res;
    tb_perr      = perr;
    if (rand_rdy) begin
      bus.res_ready = 1'($urandom_range(0, 1));
      bus.clr_err   = ($urandom_range(0, 15) == 0);
    end
    @(posedge clk);
    #1;
    bus.begin_in = 1'b0;
    bus.push_a   = 1'b0;
    bus.push_q   = 1'b0;
    bus.clr_err  = 1'b0;
    tb_done      = 1'b0;
    tb_perr      = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 2'b00, 1'b0, 1'b0, 8'($urandom), 1'b0, 18'd0, 1'b0);
  endtask

  task automatic gaps(input int maxgap);
    idle(int'($urandom_range(0, maxgap)));
  endtask

  // Push phase of a legal transaction (begin already issued).
  task automatic finish_op(input logic [1:0] op, input logic [7:0] a, input logic [7:0] q,
                           input int maxgap);
    case (op)
      2'b00, 2'b01: drive(1'b0, op, 1'b1, 1'b0, a, 1'b1, ref_result(op, a, q), 1'b0);
      2'b10: begin
        drive(1'b0, op, 1'b1, 1'b0, a, 1'b0, 18'd0, 1'b0);
        gaps(maxgap);
        drive(1'b0, op, 1'b0, 1'b1, q, 1'b1, ref_result(op, a, q), 1'b0);
      end
      default: begin
        drive(1'b0, op, 1'b0, 1'b1, q, 1'b0, 18'd0, 1'b0);
        gaps(maxgap);
        drive(1'b0, op, 1'b1, 1'b0, a, 1'b1, ref_result(op, a, q), 1'b0);
      end
    endcase
  endtask

  task automatic run_op(input logic [1:0] op, input logic [7:0] a, input logic [7:0] q,
                        input int maxgap);
    drive(1'b1, op, 1'b0, 1'b0, 8'($urandom), 1'b0, 18'd0, 1'b0);
    gaps(maxgap);
    finish_op(op, a, q, maxgap);
  endtask

  task automatic rand_error(input int kind);
    logic [1:0] op;
    logic [1:0] op2;
    logic       sel;
    op  = 2'($urandom_range(0, 3));
    op2 = 2'($urandom_range(0, 3));
    sel = 1'($urandom_range(0, 1));
    case (kind)
      0: drive(1'b0, op, sel, ~sel, 8'($urandom), 1'b0, 18'd0, 1'b1);
      1: begin
        // Wrong first strobe, or both strobes together.
        drive(1'b1, op, 1'b0, 1'b0, 8'($urandom), 1'b0, 18'd0, 1'b0);
        if (sel) drive(1'b0, op, 1'b1, 1'b1, 8'($urandom), 1'b0, 18'd0, 1'b1);
        else if (op == 2'b11) drive(1'b0, op, 1'b1, 1'b0, 8'($urandom), 1'b0, 18'd0, 1'b1);
        else drive(1'b0, op, 1'b0, 1'b1, 8'($urandom), 1'b0, 18'd0, 1'b1);
      end
      2: begin
        // BEGIN while a capture is open restarts with the new op.
        drive(1'b1, op, 1'b0, 1'b0, 8'($urandom), 1'b0, 18'd0, 1'b0);
        drive(1'b1, op2, sel, 1'b0, 8'($urandom), 1'b0, 18'd0, 1'b1);
        gaps(1);
        finish_op(op2, 8'($urandom), 8'($urandom), 1);
      end
      default: begin
        // Two-push op whose second push has both strobes high.
        op = {1'b1, sel};
        drive(1'b1, op, 1'b0, 1'b0, 8'($urandom), 1'b0, 18'd0, 1'b0);
        if (op == 2'b11) drive(1'b0, op, 1'b0, 1'b1, 8'($urandom), 1'b0, 18'd0, 1'b0);
        else             drive(1'b0, op, 1'b1, 1'b0, 8'($urandom), 1'b0, 18'd0, 1'b0);
        drive(1'b0, op, 1'b1, 1'b1, 8'($urandom), 1'b0, 18'd0, 1'b1);
      end
    endcase
  endtask

  initial begin
    bus.begin_in  = 1'b0;
    bus.op_code   = 2'b00;
    bus.push_a    = 1'b0;
    bus.push_q    = 1'b0;
    bus.outbus    = '0;
    bus.res_ready = 1'b0;
    bus.clr_err   = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 32'(bus.res_valid), 32'd0);
    check("rst_data", 32'({bus.res_op, bus.res_hi, bus.res_lo}), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_errs", 32'({bus.err_proto, bus.err_ovr}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // add: sign-extended result
    run_op(2'b00, 8'hF3, 8'h00, 0);
    check("add_valid", 32'(bus.res_valid), 32'd1);
    check("add_res", 32'({bus.res_op, bus.res_hi, bus.res_lo}), 32'h000FFF3);
    bus.res_ready = 1'b1;
    idle(1);
    bus.res_ready = 1'b0;

    // mul drained immediately
    bus.res_ready = 1'b1;
    run_op(2'b10, 8'h12, 8'h34, 1);
    check("mul_res", 32'({bus.res_hi, bus.res_lo}), 32'h1234);
    idle(1);
    check("mul_gone", 32'(bus.res_valid), 32'd0);
    bus.res_ready = 1'b0;

    // div: quotient first, remainder second
    run_op(2'b11, 8'h02, 8'h05, 0);
    check("div_res", 32'({bus.res_op, bus.res_hi, bus.res_lo}), 32'h30205);
    bus.res_ready = 1'b1;
    idle(1);
    bus.res_ready = 1'b0;

    // overrun: third result dropped
    run_op(2'b00, 8'h11, 8'h00, 0);
    run_op(2'b01, 8'h82, 8'h00, 0);
    run_op(2'b00, 8'h33, 8'h00, 0);
    check("ovr_flag", 32'(bus.err_ovr), 32'd1);
    check("ovr_head0", 32'({bus.res_op, bus.res_hi, bus.res_lo}), 32'h00011);
    bus.res_ready = 1'b1;
    idle(1);
    check("ovr_head1", 32'({bus.res_op, bus.res_hi, bus.res_lo}), 32'h1FF82);
    idle(1);
    check("ovr_drained", 32'(bus.res_valid), 32'd0);
    bus.res_ready = 1'b0;
    bus.clr_err = 1'b1;
    idle(1);
    check("ovr_cleared", 32'(bus.err_ovr), 32'd0);

    // protocol errors
    drive(1'b0, 2'b00, 1'b0, 1'b1, 8'h55, 1'b0, 18'd0, 1'b1);
    check("proto_idle", 32'(bus.err_proto), 32'd1);
    bus.clr_err = 1'b1;
    idle(1);
    check("proto_clr", 32'(bus.err_proto), 32'd0);
    drive(1'b1, 2'b10, 1'b0, 1'b0, 8'h00, 1'b0, 18'd0, 1'b0);
    check("busy_wait1", 32'(bus.busy), 32'd1);
    drive(1'b0, 2'b10, 1'b0, 1'b1, 8'h34, 1'b0, 18'd0, 1'b1);
    check("proto_mul", 32'({bus.err_proto, bus.busy, bus.res_valid}), 32'b100);
    // error and clear on the same edge: error wins
    bus.clr_err = 1'b1;
    drive(1'b0, 2'b00, 1'b1, 1'b0, 8'h00, 1'b0, 18'd0, 1'b1);
    check("err_beats_clr", 32'(bus.err_proto), 32'd1);
    bus.clr_err = 1'b1;
    idle(1);

    // full FIFO with a pop on the completing edge: no overrun
    run_op(2'b00, 8'h01, 8'h00, 0);
    run_op(2'b00, 8'h02, 8'h00, 0);
    drive(1'b1, 2'b00, 1'b0, 1'b0, 8'h00, 1'b0, 18'd0, 1'b0);
    bus.res_ready = 1'b1;
    drive(1'b0, 2'b00, 1'b1, 1'b0, 8'h03, 1'b1, ref_result(2'b00, 8'h03, 8'h00), 1'b0);
    bus.res_ready = 1'b0;
    check("full_pop_ovr", 32'(bus.err_ovr), 32'd0);
    check("full_pop_head", 32'(bus.res_lo), 32'h02);
    bus.res_ready = 1'b1;
    idle(2);
    bus.res_ready = 1'b0;

    // count=1 with push and pop together: head moves to the new entry
    run_op(2'b00, 8'h0A, 8'h00, 0);
    drive(1'b1, 2'b00, 1'b0, 1'b0, 8'h00, 1'b0, 18'd0, 1'b0);
    bus.res_ready = 1'b1;
    drive(1'b0, 2'b00, 1'b1, 1'b0, 8'h0B, 1'b1, ref_result(2'b00, 8'h0B, 8'h00), 1'b0);
    bus.res_ready = 1'b0;
    check("pushpop_head", 32'(bus.res_lo), 32'h0B);

    // asynchronous reset in the middle of a mul
    drive(1'b0, 2'b00, 1'b1, 1'b0, 8'h00, 1'b0, 18'd0, 1'b1);
    drive(1'b1, 2'b10, 1'b0, 1'b0, 8'h00, 1'b0, 18'd0, 1'b0);
    drive(1'b0, 2'b10, 1'b1, 1'b0, 8'h77, 1'b0, 18'd0, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(bus.res_valid), 32'd0);
    check("arst_data", 32'({bus.res_op, bus.res_hi, bus.res_lo}), 32'd0);
    check("arst_flags", 32'({bus.busy, bus.err_proto, bus.err_ovr}), 32'd0);
    check("arst_state", 32'(dbg_state), 32'd0);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_op(2'b00, 8'h7F, 8'h00, 0);
    check("post_rst_add", 32'({bus.res_valid, bus.res_hi, bus.res_lo}), 32'h1007F);
    bus.res_ready = 1'b1;
    idle(1);

    // randomized traffic
    rand_rdy = 1'b1;
    repeat (300) begin
      int r;
      r = int'($urandom_range(0, 11));
      if (r < 4) rand_error(r);
      else run_op(2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom), 2);
      gaps(1);
    end
    rand_rdy = 1'b0;
    bus.res_ready = 1'b1;
    bus.clr_err = 1'b0;
    idle(4);
    check("final_drain", 32'(bus.res_valid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
